// File: rtl/ss_share_sched.sv
// Shares one SS sequence-processing datapath between two requesters that each
// load an N-word frame; frames are served round-robin and results are tagged by requester.
module ss_share_sched #(
    parameter int DW      = 6,
    parameter int RW      = 3,
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en0,
    input  logic [DW-1:0] wr_data0,
    output logic          full0,
    input  logic          wr_en1,
    input  logic [DW-1:0] wr_data1,
    output logic          full1,
    output logic          ss_start,
    output logic [DW-1:0] ss_in,
    input  logic          ss_ready,
    input  logic [RW-1:0] ss_out,
    output logic          busy,
    output logic          res_valid,
    output logic          res_id,
    output logic [RW-1:0] res_data,
    output logic          timeout_err
);
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, START, SEND, WAIT, DONE} state_t;

    state_t        state_reg;
    logic          grant_reg;
    logic          last_grant_reg;
    logic [CW-1:0] idx_reg;
    logic [TW-1:0] wait_cnt_reg;
    logic          ready_low_reg;
    logic          ss_start_reg;
    logic [DW-1:0] ss_in_reg;
    logic          res_valid_reg;
    logic          res_id_reg;
    logic [RW-1:0] res_data_reg;
    logic          timeout_err_reg;

    logic [1:0]          wr_en_vec;
    logic [1:0][DW-1:0]  wr_data_vec;
    logic [1:0]          full_vec;
    logic [1:0]          clr_vec;
    logic [1:0][DW-1:0]  rd_word;
    logic [AW-1:0]       rd_addr;
    logic [CW-1:0]       idx_inc;
    logic                last_word;
    logic                pick;

    assign wr_en_vec   = {wr_en1, wr_en0};
    assign wr_data_vec = {wr_data1, wr_data0};

    assign idx_inc   = idx_reg + CW'(1);
    assign last_word = (state_reg == SEND) && (idx_reg == CW'(N - 1));
    // In START the first word is fetched; in SEND the word after the one on ss_in.
    assign rd_addr   = (state_reg == SEND) ? idx_inc[AW-1:0] : '0;

    // Ties go to the requester that was not served last.
    assign pick = (&full_vec) ? ~last_grant_reg : full_vec[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic [DW-1:0] mem_reg [N];
            logic [CW-1:0] cnt_reg;
            logic          full_reg;

            assign clr_vec[gi]  = last_word && (grant_reg == 1'(gi));
            assign full_vec[gi] = full_reg;
            assign rd_word[gi]  = mem_reg[rd_addr];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < N; i++) begin
                        mem_reg[i] <= '0;
                    end
                    cnt_reg  <= '0;
                    full_reg <= 1'b0;
                end else if (clr_vec[gi]) begin
                    cnt_reg  <= '0;
                    full_reg <= 1'b0;
                end else if (wr_en_vec[gi] && !full_reg) begin
                    mem_reg[cnt_reg[AW-1:0]] <= wr_data_vec[gi];
                    cnt_reg                  <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(N - 1)) begin
                        full_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            idx_reg         <= '0;
            wait_cnt_reg    <= '0;
            ready_low_reg   <= 1'b0;
            ss_start_reg    <= 1'b0;
            ss_in_reg       <= '0;
            res_valid_reg   <= 1'b0;
            res_id_reg      <= 1'b0;
            res_data_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            ss_start_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|full_vec) begin
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        ss_start_reg   <= 1'b1;
                        ss_in_reg      <= '0;
                        state_reg      <= START;
                    end
                end
                START: begin
                    ss_in_reg     <= rd_word[grant_reg];
                    idx_reg       <= '0;
                    ready_low_reg <= 1'b0;
                    state_reg     <= SEND;
                end
                SEND: begin
                    if (idx_reg == CW'(N - 1)) begin
                        ss_in_reg    <= '0;
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end else begin
                        ss_in_reg <= rd_word[grant_reg];
                        idx_reg   <= idx_inc;
                    end
                end
                WAIT: begin
                    // A Ready that was already high before the frame is ignored
                    // until SS has been seen low at least once.
                    if (!ss_ready) begin
                        ready_low_reg <= 1'b1;
                    end
                    wait_cnt_reg <= wait_cnt_reg + TW'(1);
                    if (ready_low_reg && ss_ready) begin
                        res_data_reg    <= ss_out;
                        timeout_err_reg <= 1'b0;
                        res_id_reg      <= grant_reg;
                        res_valid_reg   <= 1'b1;
                        state_reg       <= DONE;
                    end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
                        res_data_reg    <= '0;
                        timeout_err_reg <= 1'b1;
                        res_id_reg      <= grant_reg;
                        res_valid_reg   <= 1'b1;
                        state_reg       <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign full0       = full_vec[0];
    assign full1       = full_vec[1];
    assign ss_start    = ss_start_reg;
    assign ss_in       = ss_in_reg;
    assign busy        = (state_reg != IDLE);
    assign res_valid   = res_valid_reg;
    assign res_id      = res_id_reg;
    assign res_data    = res_data_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_ss_share_sched.sv
// Scoreboard bench for ss_share_sched: stimulus queues expected words/results,
// a monitor compares them as the DUT streams frames and reports results.
module tb_ss_share_sched;
    localparam int DW      = 6;
    localparam int RW      = 3;
    localparam int N       = 8;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en0 = 1'b0;
    logic [DW-1:0] wr_data0 = '0;
    logic          full0;
    logic          wr_en1 = 1'b0;
    logic [DW-1:0] wr_data1 = '0;
    logic          full1;
    logic          ss_start;
    logic [DW-1:0] ss_in;
    logic          ss_ready = 1'b1;
    logic [RW-1:0] ss_out = '0;
    logic          busy;
    logic          res_valid;
    logic          res_id;
    logic [RW-1:0] res_data;
    logic          timeout_err;

    ss_share_sched #(.DW(DW), .RW(RW), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wr_en0(wr_en0), .wr_data0(wr_data0), .full0(full0),
        .wr_en1(wr_en1), .wr_data1(wr_data1), .full1(full1),
        .ss_start(ss_start), .ss_in(ss_in), .ss_ready(ss_ready), .ss_out(ss_out),
        .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic id; logic [RW-1:0] data; logic tmo; int lat; } res_t;
    typedef struct { logic [RW-1:0] val; int low; } ss_t;

    res_t          exp_res[$];
    logic [DW-1:0] exp_words[$];
    ss_t           ss_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit stale_mode = 1'b0;

    logic [DW-1:0] w0 [10];
    logic [DW-1:0] w1 [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input int id, input logic [RW-1:0] val, input int low,
                                input bit tmo, input bit with_res);
        res_t r;
        ss_t  s;
        for (int i = 0; i < N; i++) exp_words.push_back(id == 1 ? w1[i] : w0[i]);
        if (!tmo) begin
            s.val = val;
            s.low = low;
            ss_q.push_back(s);
        end
        if (with_res) begin
            r.id   = id[0];
            r.data = tmo ? '0 : val;
            r.tmo  = tmo;
            r.lat  = tmo ? (1 + N + TIMEOUT) : (2 + N + low);
            exp_res.push_back(r);
        end
    endtask

    task automatic load(input bit en0, input bit en1, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wr_en0 = en0; wr_data0 = w0[i];
            wr_en1 = en1; wr_data1 = w1[i];
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_res.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_res.size(), 0);
    endtask

    // SS model: drops Ready at Start, raises it with the queued result after N + 1 + low cycles.
    int          ss_k = -1;
    int          ss_low = 1;
    logic [RW-1:0] ss_val = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                ss_k = -1;
            end else if (ss_start && !stale_mode) begin
                if (ss_q.size() > 0) begin
                    ss_t e;
                    e = ss_q.pop_front();
                    ss_low = e.low;
                    ss_val = e.val;
                end
                ss_ready = 1'b0;
                ss_k = 0;
            end else if (ss_k >= 0) begin
                ss_k++;
                if (ss_k == N + 1 + ss_low) begin
                    ss_ready = 1'b1;
                    ss_out   = ss_val;
                    ss_k     = -1;
                end
            end
        end
    end

    // Monitor: checks streamed words, idle ss_in, buffer release and tagged results.
    int mon_send_left = 0;
    bit mon_chk_wait  = 1'b0;
    int mon_cyc = 0;
    int mon_t0  = 0;
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rst) begin
                mon_send_left = 0;
                mon_chk_wait  = 1'b0;
            end else begin
                if (mon_chk_wait) begin
                    mon_chk_wait = 1'b0;
                    check("wait_ss_in_zero", ss_in, 0);
                    if (exp_res.size() == 0) check("wait_owner_known", 0, 1);
                    else check("full_released", exp_res[0].id ? full1 : full0, 0);
                end
                if (mon_send_left > 0) begin
                    check("start_one_cycle", ss_start, 0);
                    if (exp_words.size() == 0) begin
                        check("word_expected", 0, 1);
                    end else begin
                        logic [DW-1:0] w;
                        w = exp_words.pop_front();
                        check("ss_in_word", ss_in, w);
                    end
                    mon_send_left--;
                    if (mon_send_left == 0) mon_chk_wait = 1'b1;
                end else if (ss_start) begin
                    check("start_ss_in_zero", ss_in, 0);
                    mon_send_left = N;
                    mon_t0 = mon_cyc;
                end
                if (res_valid) begin
                    if (exp_res.size() == 0) begin
                        check("res_expected", 0, 1);
                    end else begin
                        res_t r;
                        r = exp_res.pop_front();
                        $display("result id=%0d data=%0d timeout=%0d latency=%0d",
                                 res_id, res_data, timeout_err, mon_cyc - mon_t0);
                        check("res_id", res_id, r.id);
                        check("res_data", res_data, r.data);
                        check("timeout_err", timeout_err, r.tmo);
                        check("latency", mon_cyc - mon_t0, r.lat);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset held with a write strobe active
        wr_en0 = 1'b1; wr_data0 = 6'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_full0", full0, 0);
        check("rst_full1", full1, 0);
        check("rst_busy", busy, 0);
        check("rst_ss_start", ss_start, 0);
        check("rst_ss_in", ss_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        wr_en0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single frame on requester 0
        w0 = '{6'd5, 6'd12, 6'd33, 6'd7, 6'd48, 6'd0, 6'd21, 6'd63, 6'd0, 6'd0};
        expect_frame(0, 3'd4, 3, 1'b0, 1'b1);
        load(1'b1, 1'b0, N);
        check("single_full0_set", full0, 1);
        check("single_idle_before_start", busy, 0);
        drain("single_drain");

        // Round-robin from a fresh reset: requester 0 wins the tie
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        w0 = '{6'd10, 6'd20, 6'd30, 6'd40, 6'd50, 6'd60, 6'd1, 6'd2, 6'd0, 6'd0};
        w1 = '{6'd3, 6'd6, 6'd9, 6'd12, 6'd15, 6'd18, 6'd21, 6'd24, 6'd0, 6'd0};
        expect_frame(0, 3'd2, 1, 1'b0, 1'b1);
        expect_frame(1, 3'd7, 5, 1'b0, 1'b1);
        load(1'b1, 1'b1, N);
        t = 0;
        while (full0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("rr_full0_released", full0, 0);
        w0 = '{6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56, 6'd0, 6'd0};
        expect_frame(0, 3'd1, 2, 1'b0, 1'b1);
        load(1'b1, 1'b0, N);
        drain("rr_drain");

        // Overflow: ten writes, only the first eight are kept
        w1 = '{6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20};
        expect_frame(1, 3'd6, 2, 1'b0, 1'b1);
        load(1'b0, 1'b1, 10);
        drain("overflow_drain");

        // Stale Ready: SS never drops Ready, so the frame times out
        stale_mode = 1'b1;
        ss_ready = 1'b1;
        ss_out = 3'd5;
        w0 = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd0, 6'd0};
        expect_frame(0, 3'd0, 0, 1'b1, 1'b1);
        load(1'b1, 1'b0, N);
        drain("stale_drain");
        stale_mode = 1'b0;

        // Reset in the middle of SEND
        w0 = '{6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47, 6'd0, 6'd0};
        expect_frame(0, 3'd3, 2, 1'b0, 1'b0);
        load(1'b1, 1'b0, N);
        t = 0;
        while (!ss_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_start_seen", ss_start, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_full0", full0, 0);
        check("abort_ss_in", ss_in, 0);
        check("abort_ss_start", ss_start, 0);
        exp_words.delete();
        ss_q.delete();
        @(negedge clk);
        check("abort_no_res_valid", res_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        w0 = '{6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd32, 6'd0, 6'd0};
        expect_frame(0, 3'd5, 2, 1'b0, 1'b1);
        load(1'b1, 1'b0, N);
        drain("after_abort_drain");

        repeat (3) @(negedge clk);
        check("words_consumed", exp_words.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ss_share_sched.md
Name: ss_share_sched

Overview:
- Scheduler that shares one SS sequence-processing datapath between two requesters.
- Each requester loads an 8-word frame of 6-bit samples into a private buffer.
- The scheduler picks pending frames round-robin, pulses SS Start and streams the 8 words into SS one per clock. It then waits for SS Ready and returns the 3-bit SS result, tagged with the requester id.
- Sits between the two sample producers and the single SS instance (clk, rst, inBus, Start, Ready, outBus).

Parameters:
- DW, 6, sample width (matches SS inBus)
- RW, 3, result width (matches SS outBus)
- N, 8, words per frame (counters sized ceil(log2(N))+1)
- TIMEOUT, 64, max cycles spent in WAIT before aborting

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- wr_en0  in  1  requester 0 write strobe
- wr_data0  in  DW  requester 0 sample
- full0  out  1  requester 0 frame complete/pending; writes ignored while high
- wr_en1  in  1  requester 1 write strobe
- wr_data1  in  DW  requester 1 sample
- full1  out  1  requester 1 frame complete/pending
- ss_start  out  1  to SS Start
- ss_in  out  DW  to SS inBus
- ss_ready  in  1  from SS Ready
- ss_out  in  RW  from SS outBus
- busy  out  1  high in every state except IDLE
- res_valid  out  1  one-cycle result strobe
- res_id  out  1  requester that owns the result
- res_data  out  RW  captured SS result (0 on timeout)
- timeout_err  out  1  qualifies res_valid; 1 = SS never became Ready

Behaviour:
- Reset (rst=0, async) clears:
  - all outputs to 0, both buffers and word counters, FSM to IDLE;
  - last_grant to 1, so requester 0 wins the first tie.
- Buffer i write: when wr_en_i=1 and full_i=0, wr_data_i goes to slot cnt_i and cnt_i increments. full_i rises the cycle after the N-th write.
- Writes while full_i=1 are dropped silently; cnt_i does not change.
- FSM states: IDLE, START, SEND, WAIT, DONE.
- IDLE:
  - if any full_i=1, grant g per round-robin; when both are full, g = ~last_grant.
  - Register g and last_grant<=g, then go to START.
- START (1 cycle):
  - ss_start=1, ss_in=0; clear idx and the ready_low flag; go to SEND.
- SEND (exactly N cycles):
  - ss_in = buf_g[idx], ss_start=0, idx increments.
  - On the cycle idx=N-1, clear full_g and cnt_g; the requester may refill from the next cycle.
  - Then go to WAIT and clear the wait counter.
- WAIT:
  - ready_low sets the first cycle ss_ready=0 is sampled, so a stale Ready left over from idle is not accepted.
  - When ready_low=1 and ss_ready=1: capture ss_out into res_data, timeout_err=0, go to DONE.
  - If the wait counter reaches TIMEOUT-1 without completion: res_data=0, timeout_err=1, go to DONE.
- DONE (1 cycle):
  - res_valid=1, res_id=g, then back to IDLE.
  - res_data, res_id and timeout_err hold their values until the next DONE.
- Latency from the START cycle to res_valid = 1 + N + (WAIT cycles) + 1.
- The other requester may load or complete its frame at any time; its frame is served on the next IDLE visit.
- Reset mid-operation (any state) aborts immediately. Buffers are lost, ss_start drops asynchronously and no res_valid is issued.
- ss_in is 0 whenever the FSM is not in SEND.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wr_en0=1 -> all outputs 0, full0=0; after release, first write lands in slot 0.
- Single frame: load req0 with 5,12,33,7,48,0,21,63; SS holds Ready low 3 cycles then high with outBus=4.
  - ss_start pulses 1 cycle, then ss_in shows 5..63 on 8 consecutive cycles.
  - res_valid=1, res_id=0, res_data=4, timeout_err=0.
- Round-robin: both frames full in the same cycle.
  - req0 is served first, then req1, then req0 again after req0 is refilled.
  - full0 drops on req0's last SEND cycle.
- Overflow: 10 writes to req1 -> only the first 8 are stored; words 9-10 are dropped; streamed data matches the first 8.
- Stale Ready: ss_ready held 1 throughout -> no capture; after TIMEOUT=64 WAIT cycles, res_valid=1, timeout_err=1, res_data=0.
- Reset mid-SEND (after 3 words): busy, full0 and ss_in are 0 immediately; a new frame after reset completes normally with res_id=0.
